datapath_rr_scheduler: RTL and testbench

//   Shares one combinational 6-bit -> 18-bit datapath between NUM_REQ requesters.

---
 rtl/datapath_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_datapath_rr_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/datapath_rr_scheduler.sv
// rtl/datapath_rr_scheduler.sv - round-robin scheduler sharing one datapath among NUM_REQ requesters
// Optional macro SCHED_STATS_EN adds per-requester saturating grant counters on grant_cnt_o.
module datapath_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DIN_W   = 6,
    parameter int DOUT_W  = 18
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DIN_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [DIN_W-1:0]           dp_in_o,
    input  logic [DOUT_W-1:0]          dp_out_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DOUT_W-1:0]          rsp_data_o,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
`ifdef SCHED_STATS_EN
    output logic                       busy_o,
    output logic [NUM_REQ*16-1:0]      grant_cnt_o
`else
    output logic                       busy_o
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [DIN_W-1:0]    dp_in_q;
    logic [DOUT_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic                rsp_valid_q;
    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     scan_idx;
    logic                accept;

    // Scan starts one past the last granted requester and wraps at NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign accept = (state_q == IDLE) && win_found && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[win_idx] = 1'b1;
        end
        busy_o = (state_q != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            dp_in_q     <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (win_found) begin
                    dp_in_q  <= req_data_i[win_idx*DIN_W +: DIN_W];
                    rsp_id_q <= win_idx;
                end
                EXEC: begin
                    rsp_data_q  <= dp_out_i;
                    rsp_valid_q <= 1'b1;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_q <= 1'b0;
                    ptr_q       <= rsp_id_q;
                end
                default: rsp_valid_q <= 1'b0;
            endcase
        end
    end

    assign dp_in_o     = dp_in_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_valid_o = rsp_valid_q;

`ifdef SCHED_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (accept && cnt_q[win_idx] != 16'hFFFF) begin
            cnt_q[win_idx] <= cnt_q[win_idx] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt_o[g*16 +: 16] = cnt_q[g];
    end
`else
`endif

endmodule

// File: tb/tb_datapath_rr_scheduler.sv
// tb/tb_datapath_rr_scheduler.sv - directed self-checking bench for datapath_rr_scheduler
module tb_datapath_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_data;
    logic [3:0]  req_ready;
    logic [5:0]  dp_in;
    logic [17:0] dp_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [17:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
`ifdef SCHED_STATS_EN
    logic [63:0] grant_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign dp_out = 18'(dp_in) * 18'd3;

    datapath_rr_scheduler #(.NUM_REQ(4), .DIN_W(6), .DOUT_W(18)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .dp_in_o     (dp_in),
        .dp_out_i    (dp_out),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
`ifdef SCHED_STATS_EN
        .busy_o      (busy),
        .grant_cnt_o (grant_cnt)
`else
        .busy_o      (busy)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ids [5];
        int dats [5];
        ids  = '{0, 1, 2, 3, 0};
        dats = '{3, 6, 9, 12, 3};

        // Reset held with every requester valid
        rst = 1'b1; req_valid = 4'hF; req_data = '0; rsp_ready = 1'b0;
        clk_n(2);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_dp_in", 32'(dp_in), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        rst = 1'b0; #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        clk_n(1);
        req_valid = 4'h0; #1;
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_ready_exec", 32'(req_ready), 32'h0);
        clk_n(1);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_id", 32'(rsp_id), 32'h0);
        rsp_ready = 1'b1;
        clk_n(1);
        rsp_ready = 1'b0; #1;
        chk("t1_rsp_done", 32'(rsp_valid), 32'h0);

        // Single op from requester 2
        req_valid = 4'b0100; req_data = {6'd0, 6'd21, 6'd0, 6'd0}; #1;
        chk("t2_ready", 32'(req_ready), 32'b0100);
        clk_n(1);
        req_valid = 4'h0; #1;
        chk("t2_dp_in", 32'(dp_in), 32'd21);
        chk("t2_ready_exec", 32'(req_ready), 32'h0);
        clk_n(1);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t2_rsp_data", 32'(rsp_data), 32'd63);
        chk("t2_rsp_id", 32'(rsp_id), 32'd2);
        rsp_ready = 1'b1;
        clk_n(1);
        rsp_ready = 1'b0;

        // Round-robin with all requesters valid, wrap 3 -> 0
        rst = 1'b1;
        clk_n(1);
        rst = 1'b0; req_valid = 4'hF; req_data = {6'd4, 6'd3, 6'd2, 6'd1}; rsp_ready = 1'b1;
        clk_n(2);
        for (int k = 0; k < 5; k++) begin
            chk("rr_valid", 32'(rsp_valid), 32'h1);
            chk("rr_id", 32'(rsp_id), 32'(ids[k]));
            chk("rr_data", 32'(rsp_data), 32'(dats[k]));
            if (k < 4) begin
                clk_n(1);
                chk("rr_gap", 32'(rsp_valid), 32'h0);
                clk_n(2);
            end
        end

        // Backpressure: response for requester 0 held while requests pend
        rsp_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clk_n(1);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_data", 32'(rsp_data), 32'd3);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        clk_n(1);
        rsp_ready = 1'b0; #1;
        chk("bp_release_valid", 32'(rsp_valid), 32'h0);
        chk("bp_release_grant", 32'(req_ready), 32'b0010);
        clk_n(1);
        chk("bp_one_accept", 32'(req_ready), 32'h0);
        chk("bp_dp_in", 32'(dp_in), 32'd2);
        clk_n(1);
        chk("bp_rsp_data", 32'(rsp_data), 32'd6);
        chk("bp_rsp_id", 32'(rsp_id), 32'd1);
        clk_n(3);
        chk("bp_hold_ready", 32'(req_ready), 32'h0);
        chk("bp_hold_valid", 32'(rsp_valid), 32'h1);

        // Reset in RESP, then in EXEC
        rst = 1'b1;
        clk_n(1);
        rst = 1'b0; #1;
        chk("rr_rst_valid", 32'(rsp_valid), 32'h0);
        chk("rr_rst_busy", 32'(busy), 32'h0);
        chk("rr_rst_ptr", 32'(req_ready), 32'h1);
        req_valid = 4'b1000; #1;
        chk("ex_grant", 32'(req_ready), 32'b1000);
        clk_n(1);
        chk("ex_busy", 32'(busy), 32'h1);
        chk("ex_dp_in", 32'(dp_in), 32'd4);
        rst = 1'b1; req_valid = 4'h0;
        clk_n(1);
        rst = 1'b0; #1;
        chk("ex_rst_busy", 32'(busy), 32'h0);
        clk_n(2);
        chk("ex_no_rsp", 32'(rsp_valid), 32'h0);
        req_valid = 4'hF; #1;
        chk("ex_rst_ptr", 32'(req_ready), 32'h1);

`ifdef SCHED_STATS_EN
        rst = 1'b1;
        clk_n(1);
        req_valid = 4'b0010; rsp_ready = 1'b1; rst = 1'b0;
        clk_n(3 * 70000);
        chk("cnt1_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
        chk("cnt0_zero", 32'(grant_cnt[15:0]), 32'h0);
        chk("cnt2_zero", 32'(grant_cnt[47:32]), 32'h0);
        chk("cnt3_zero", 32'(grant_cnt[63:48]), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
